ps2_mouse_tracker: RTL and testbench

Receive-only PS/2 mouse front end: synchronizes the PS/2 clock/data lines, deserializes 11-bit device-to-host frames, assembles standard 3-byte movement packets and integrates the signed deltas into an absolute, screen-clamped cursor position. It is the producer of the `mouse_x`/`mouse_y` pair consumed by the cursor overlay stage of the VGA pipeline. Mouse initialization (0xF4 enable reporting) belongs to a separate host-transmit block; this block never drives the PS/2 lines.

---
 rtl/ps2_pkg.sv | 48 ++++
 rtl/ps2_rx_byte.sv | 133 +++++++++++++
 rtl/ps2_mouse_tracker.sv | 132 +++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receive path: bit-level FSM states,
// byte-0 field positions of a standard 3-byte movement packet, and a helper
// that clamps a signed 12-bit coordinate into the visible range.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int B0_LEFT  = 0;
    localparam int B0_RIGHT = 1;
    localparam int B0_MID   = 2;
    localparam int B0_SYNC  = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Byte-0 fields kept for decoding; the sync bit is implied by acceptance.
    typedef struct packed {
        logic       yovf;
        logic       xovf;
        logic       ysign;
        logic       xsign;
        logic [2:0] btn;
    } b0_flags_t;

    // Negative values (bit 11 set) clamp to 0, values above max_v clamp to max_v.
    function automatic logic [9:0] clamp_coord(input logic [11:0] v,
                                               input logic [11:0] max_v);
        logic [9:0] r;
        if (v[11]) begin
            r = 10'd0;
        end else if (v > max_v) begin
            r = max_v[9:0];
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host byte receiver: synchronizes the raw lines, detects the
// falling edge of the PS/2 clock, shifts in an 11-bit frame, checks odd parity
// and the stop bit, and aborts a frame that stalls for TIMEOUT_CYCLES.
module ps2_rx_byte #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err
);
    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          ps2_clk_meta_q, ps2_clk_sync_q;
    logic          ps2_data_meta_q, ps2_data_sync_q;
    logic [1:0]    clk_hist_q;
    logic          fall_edge;
    logic          sample_bit;

    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_ok_q, parity_ok_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_hit;

    // Two-stage synchronizers plus clock history; idle level of both lines is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
            clk_hist_q      <= 2'b11;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
            clk_hist_q      <= {clk_hist_q[0], ps2_clk_sync_q};
        end
    end

    // High followed by two lows filters single-sample glitches on the clock line.
    assign fall_edge  = ({clk_hist_q, ps2_clk_sync_q} == 3'b100);
    assign sample_bit = ps2_data_sync_q;

    // Frame FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            parity_ok_q <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_ok_q <= parity_ok_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Next-state logic: an edge in the same cycle as the terminal count wins.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_ok_d = parity_ok_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;

        if (state_q == ST_IDLE || fall_edge) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        timeout_hit = (state_q != ST_IDLE) && !fall_edge &&
                      (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1));

        if (timeout_hit) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else if (fall_edge) begin
            case (state_q)
                ST_IDLE: begin
                    if (!sample_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d = {sample_bit, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    parity_ok_d = ^{shift_q, sample_bit};
                    state_d     = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (sample_bit && parity_ok_q) begin
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign byte_err   = err_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: gathers 3-byte movement packets from the byte receiver,
// decodes the signed deltas and integrates them into a clamped screen cursor.
module ps2_mouse_tracker #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic [2:0] buttons,
    output logic       packet_valid,
    output logic       frame_err
);
    import ps2_pkg::*;

    localparam logic [11:0] X_MAX  = 12'(SCREEN_W - 1);
    localparam logic [11:0] Y_MAX  = 12'(SCREEN_H - 1);
    localparam logic [9:0]  X_HOME = 10'(SCREEN_W / 2);
    localparam logic [9:0]  Y_HOME = 10'(SCREEN_H / 2);

    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_err;

    logic [1:0]  idx_q, idx_d;
    b0_flags_t   b0_q, b0_d;
    logic [7:0]  b1_q, b1_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [2:0]  btn_q, btn_d;
    logic        pv_q, pv_d;

    logic [8:0]  dx, dy;
    logic [11:0] x_sum, y_diff;

    ps2_rx_byte #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err)
    );

    // Delta decode; the third byte is consumed straight from the receiver.
    always_comb begin
        dx     = b0_q.xovf ? 9'd0 : {b0_q.xsign, b1_q};
        dy     = b0_q.yovf ? 9'd0 : {b0_q.ysign, byte_data};
        x_sum  = {2'b00, x_q} + {{3{dx[8]}}, dx};
        // PS/2 reports up as positive; screen rows grow downward.
        y_diff = {2'b00, y_q} - {{3{dy[8]}}, dy};
    end

    // Packet assembler and cursor accumulator next-state.
    always_comb begin
        idx_d = idx_q;
        b0_d  = b0_q;
        b1_d  = b1_q;
        x_d   = x_q;
        y_d   = y_q;
        btn_d = btn_q;
        pv_d  = 1'b0;

        if (byte_err) begin
            idx_d = 2'd0;
        end else if (byte_valid) begin
            case (idx_q)
                2'd0: begin
                    // Without the always-one bit this cannot be a header byte: resync.
                    if (byte_data[B0_SYNC]) begin
                        b0_d.yovf  = byte_data[B0_YOVF];
                        b0_d.xovf  = byte_data[B0_XOVF];
                        b0_d.ysign = byte_data[B0_YSIGN];
                        b0_d.xsign = byte_data[B0_XSIGN];
                        b0_d.btn   = {byte_data[B0_MID], byte_data[B0_RIGHT],
                                      byte_data[B0_LEFT]};
                        idx_d      = 2'd1;
                    end
                end
                2'd1: begin
                    b1_d  = byte_data;
                    idx_d = 2'd2;
                end
                2'd2: begin
                    x_d   = clamp_coord(x_sum, X_MAX);
                    y_d   = clamp_coord(y_diff, Y_MAX);
                    btn_d = b0_q.btn;
                    pv_d  = 1'b1;
                    idx_d = 2'd0;
                end
                default: begin
                    idx_d = 2'd0;
                end
            endcase
        end
    end

    // Assembler and cursor registers; reset centres the cursor and drops partial packets.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= 2'd0;
            b0_q  <= '0;
            b1_q  <= 8'd0;
            x_q   <= X_HOME;
            y_q   <= Y_HOME;
            btn_q <= 3'd0;
            pv_q  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            b0_q  <= b0_d;
            b1_q  <= b1_d;
            x_q   <= x_d;
            y_q   <= y_d;
            btn_q <= btn_d;
            pv_q  <= pv_d;
        end
    end

    assign mouse_x      = x_q;
    assign mouse_y      = y_q;
    assign buttons      = btn_q;
    assign packet_valid = pv_q;
    assign frame_err    = byte_err;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Testbench for ps2_mouse_tracker: drives PS/2 frames, queues the expected
// cursor state per packet and compares it when packet_valid pulses.
module tb_ps2_mouse_tracker;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] mouse_x;
    logic [9:0] mouse_y;
    logic [2:0] buttons;
    logic       packet_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_mouse_tracker #(
        .SCREEN_W       (640),
        .SCREEN_H       (480),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .mouse_x      (mouse_x),
        .mouse_y      (mouse_y),
        .buttons      (buttons),
        .packet_valid (packet_valid),
        .frame_err    (frame_err)
    );

    typedef struct {
        int x;
        int y;
        int b;
    } exp_t;

    typedef struct {
        bit         rst;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         ex;
        int         ey;
        int         eb;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];
    int   checks     = 0;
    int   bad        = 0;
    int   err_pulses = 0;
    int   pv_pulses  = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
        end
    endtask

    // Scoreboard consumer and pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (frame_err) err_pulses++;
        if (packet_valid) begin
            pv_pulses++;
            $display("pkt: x=%0d y=%0d buttons=%b", mouse_x, mouse_y, buttons);
            if (sb_q.size() == 0) begin
                check("unexpected_packet", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("pkt_x", int'(mouse_x), e.x);
                check("pkt_y", int'(mouse_y), e.y);
                check("pkt_buttons", int'(buttons), e.b);
            end
        end
    end

    // One PS/2 frame (or its first nbits bits); data changes while ps2_clk is high.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            #120;
            ps2_clk = 1'b0;
            #250;
            ps2_clk = 1'b1;
            #130;
        end
        ps2_data = 1'b1;
        #1000;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int ex, input int ey,
                               input int eb);
        exp_t e;
        int   n;
        e.x = ex;
        e.y = ey;
        e.b = eb;
        sb_q.push_back(e);
        $display("send: %02h %02h %02h", b0, b1, b2);
        send_frame(b0, 1'b0, FRAME_BITS);
        send_frame(b1, 1'b0, FRAME_BITS);
        send_frame(b2, 1'b0, FRAME_BITS);
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("packet_arrived", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"}, int'(mouse_x), 320);
        check({tag, "_y"}, int'(mouse_y), 240);
        check({tag, "_buttons"}, int'(buttons), 0);
        check({tag, "_pv"}, int'(packet_valid), 0);
        check({tag, "_ferr"}, int'(frame_err), 0);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int p0;

        vecs[0] = '{1'b1, 8'h09, 8'h05, 8'h03, 325, 237, 1};
        vecs[1] = '{1'b1, 8'h38, 8'hF6, 8'hFB, 310, 245, 0};
        vecs[2] = '{1'b1, 8'h08, 8'hFF, 8'h00, 575, 240, 0};
        vecs[3] = '{1'b0, 8'h08, 8'hFF, 8'h00, 639, 240, 0};
        vecs[4] = '{1'b0, 8'h18, 8'h00, 8'h00, 383, 240, 0};
        vecs[5] = '{1'b0, 8'h18, 8'h00, 8'h00, 127, 240, 0};
        vecs[6] = '{1'b0, 8'h18, 8'h00, 8'h00, 0,   240, 0};
        vecs[7] = '{1'b0, 8'h48, 8'h10, 8'h04, 0,   236, 0};

        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();
        check_reset_state("reset");
        repeat (20) @(negedge clk);
        check("reset_no_pulses", pv_pulses + err_pulses, 0);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rst) do_reset();
            send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2,
                        vecs[i].ex, vecs[i].ey, vecs[i].eb);
        end
        check("table_err_pulses", err_pulses, 0);

        // Bad parity on byte 1: error pulse, no packet, cursor stays home.
        do_reset();
        e0 = err_pulses;
        p0 = pv_pulses;
        send_frame(8'h09, 1'b0, FRAME_BITS);
        send_frame(8'h05, 1'b1, FRAME_BITS);
        check("parity_err_pulse", err_pulses - e0, 1);
        check("parity_no_packet", pv_pulses - p0, 0);
        check("parity_x_held", int'(mouse_x), 320);
        send_packet(8'h09, 8'h05, 8'h03, 325, 237, 1);

        // Partial frame then silence: timeout error.
        e0 = err_pulses;
        send_frame(8'h09, 1'b0, 5);
        repeat (1500) @(negedge clk);
        check("timeout_err_pulse", err_pulses - e0, 1);
        send_packet(8'h09, 8'h05, 8'h03, 330, 234, 1);

        // Stray byte without sync bit at index 0: silently dropped.
        e0 = err_pulses;
        p0 = pv_pulses;
        send_frame(8'h00, 1'b0, FRAME_BITS);
        check("stray_no_err", err_pulses - e0, 0);
        check("stray_no_packet", pv_pulses - p0, 0);
        send_packet(8'h09, 8'h05, 8'h03, 335, 231, 1);

        // Reset during bit 4 of byte 1 discards the partial packet.
        send_frame(8'h09, 1'b0, FRAME_BITS);
        send_frame(8'h05, 1'b0, 6);
        e0 = err_pulses;
        do_reset();
        check_reset_state("midreset");
        repeat (1500) @(negedge clk);
        check("midreset_no_err", err_pulses - e0, 0);
        send_packet(8'h09, 8'h05, 8'h03, 325, 237, 1);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
